rgb_led_ctrl: RTL and testbench

- Arbitrated RGB LED controller between status sources and the SB_RGBA_DRV PWM inputs (RGB0PWM..RGB2PWM).
- Two requesters (req 0 = high priority, e.g. error; req 1 = low priority, e.g. heartbeat/host status) each present a colour, mode and brightness.
- The block grants one requester, generates the per-channel PWM, and sequences blink/breathe patterns from a frame-based timebase.
- Runs on the LF oscillator domain (10 kHz nominal).

---
 rtl/rgb_led_pkg.sv | 27 ++
 rtl/rgb_pattern_gen.sv | 102 ++++++++++
 rtl/rgb_led_ctrl.sv | 122 ++++++++++++
 tb/tb_rgb_led_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_led_pkg.sv
// Shared encodings for the arbitrated RGB LED controller: pattern modes,
// arbiter states, ramp direction and colour channel indices.
package rgb_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
    } arb_state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } ramp_dir_e;

    localparam int COL_R = 0;
    localparam int COL_G = 1;
    localparam int COL_B = 2;

endpackage

// File: rtl/rgb_pattern_gen.sv
// Frame-based pattern sequencer: step prescaler, blink phase and breathe ramp,
// and the mode mux that turns the shadow level into a PWM duty value.
module rgb_pattern_gen
    import rgb_led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_FRAMES = 4,
    parameter int BREATHE_INC = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                frame_wrap,
    input  logic                restart,
    input  mode_e               mode,
    input  logic [PWM_BITS-1:0] level,
    output logic [PWM_BITS-1:0] duty
);

    localparam int                  PRESC_W    = 16;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_FRAMES - 1);
    localparam logic [PWM_BITS-1:0] RAMP_MAX   = '1;
    localparam logic [PWM_BITS:0]   INC_EXT    = (PWM_BITS + 1)'(BREATHE_INC);

    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  phase_q, phase_d;
    logic [PWM_BITS-1:0]   ramp_q, ramp_d;
    ramp_dir_e             dir_q, dir_d;
    logic [PWM_BITS:0]     step_res;
    logic [2*PWM_BITS-1:0] prod;

    // Result MSB flags that the ramp hit its rail and must reverse.
    function automatic logic [PWM_BITS:0] ramp_up_sat(input logic [PWM_BITS-1:0] r);
        logic [PWM_BITS:0] s;
        s = {1'b0, r} + INC_EXT;
        if (s >= {1'b0, RAMP_MAX}) begin
            return {1'b1, RAMP_MAX};
        end
        return {1'b0, s[PWM_BITS-1:0]};
    endfunction

    function automatic logic [PWM_BITS:0] ramp_down_sat(input logic [PWM_BITS-1:0] r);
        if ({1'b0, r} <= INC_EXT) begin
            return {1'b1, {PWM_BITS{1'b0}}};
        end
        return {1'b0, r - INC_EXT[PWM_BITS-1:0]};
    endfunction

    always_comb begin
        presc_d  = presc_q;
        phase_d  = phase_q;
        ramp_d   = ramp_q;
        dir_d    = dir_q;
        step_res = '0;
        if (frame_wrap) begin
            if (restart) begin
                presc_d = '0;
                phase_d = 1'b1;
                ramp_d  = '0;
                dir_d   = DIR_UP;
            end else if (presc_q >= PRESC_LAST) begin
                presc_d = '0;
                phase_d = !phase_q;
                if (dir_q == DIR_UP) begin
                    step_res = ramp_up_sat(ramp_q);
                    if (step_res[PWM_BITS]) dir_d = DIR_DOWN;
                end else begin
                    step_res = ramp_down_sat(ramp_q);
                    if (step_res[PWM_BITS]) dir_d = DIR_UP;
                end
                ramp_d = step_res[PWM_BITS-1:0];
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_comb begin
        prod = {{PWM_BITS{1'b0}}, level} * {{PWM_BITS{1'b0}}, ramp_q};
        duty = '0;
        unique case (mode)
            MODE_OFF:     duty = '0;
            MODE_SOLID:   duty = level;
            MODE_BLINK:   duty = phase_q ? level : '0;
            MODE_BREATHE: duty = prod[2*PWM_BITS-1:PWM_BITS];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q <= '0;
            phase_q <= 1'b1;
            ramp_q  <= '0;
            dir_q   <= DIR_UP;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            ramp_q  <= ramp_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: rtl/rgb_led_ctrl.sv
// Two-requester RGB LED controller: frame-synchronous priority arbiter,
// shadowed request fields and per-channel PWM comparator for SB_RGBA_DRV.
module rgb_led_ctrl
    import rgb_led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_FRAMES = 4,
    parameter int BREATHE_INC = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req,
    input  logic [2:0]          color0,
    input  logic [1:0]          mode0,
    input  logic [PWM_BITS-1:0] level0,
    input  logic [2:0]          color1,
    input  logic [1:0]          mode1,
    input  logic [PWM_BITS-1:0] level1,
    output logic [1:0]          gnt,
    output logic                frame_end,
    output logic [2:0]          pwm
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                frame_end_q, frame_end_d;
    arb_state_e          state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [2:0]          color_q, color_d;
    mode_e               mode_q, mode_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [2:0]          pwm_q, pwm_d;
    logic                wrap;
    logic                restart;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_eff;

    assign wrap = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        frame_end_d = wrap;
        state_d     = state_q;
        gnt_d       = gnt_q;
        color_d     = color_q;
        mode_d      = mode_q;
        level_d     = level_q;
        if (wrap) begin
            // Every state resolves identically: req0 wins, then req1, else idle.
            if (req[0])      state_d = ARB_G0;
            else if (req[1]) state_d = ARB_G1;
            else             state_d = ARB_IDLE;
            unique case (state_d)
                ARB_G0: begin
                    gnt_d   = 2'b01;
                    color_d = color0;
                    mode_d  = mode_e'(mode0);
                    level_d = level0;
                end
                ARB_G1: begin
                    gnt_d   = 2'b10;
                    color_d = color1;
                    mode_d  = mode_e'(mode1);
                    level_d = level1;
                end
                default: begin
                    gnt_d   = 2'b00;
                    color_d = '0;
                    mode_d  = MODE_OFF;
                    level_d = '0;
                end
            endcase
        end
        restart  = wrap && (state_d != state_q);
        duty_eff = (state_q == ARB_IDLE) ? '0 : duty;
        pwm_d[COL_R] = color_q[COL_R] & (cnt_q < duty_eff);
        pwm_d[COL_G] = color_q[COL_G] & (cnt_q < duty_eff);
        pwm_d[COL_B] = color_q[COL_B] & (cnt_q < duty_eff);
    end

    rgb_pattern_gen #(
        .PWM_BITS    (PWM_BITS),
        .STEP_FRAMES (STEP_FRAMES),
        .BREATHE_INC (BREATHE_INC)
    ) u_pattern (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_wrap (wrap),
        .restart    (restart),
        .mode       (mode_q),
        .level      (level_q),
        .duty       (duty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            frame_end_q <= 1'b0;
            state_q     <= ARB_IDLE;
            gnt_q       <= 2'b00;
            color_q     <= '0;
            mode_q      <= MODE_OFF;
            level_q     <= '0;
            pwm_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            frame_end_q <= frame_end_d;
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            color_q     <= color_d;
            mode_q      <= mode_d;
            level_q     <= level_d;
            pwm_q       <= pwm_d;
        end
    end

    assign gnt       = gnt_q;
    assign frame_end = frame_end_q;
    assign pwm       = pwm_q;

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Frame-level bench for rgb_led_ctrl: per-frame vectors drive the requesters
// mid-frame and queue the expected grant and per-channel on-time of the next frame.
module tb_rgb_led_ctrl;

    localparam int PWM_BITS    = 8;
    localparam int STEP_FRAMES = 2;
    localparam int BREATHE_INC = 16;
    localparam int FRAME       = 256;
    localparam int NVEC        = 19;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [1:0]          req = '0;
    logic [2:0]          color0 = '0;
    logic [1:0]          mode0 = '0;
    logic [PWM_BITS-1:0] level0 = '0;
    logic [2:0]          color1 = '0;
    logic [1:0]          mode1 = '0;
    logic [PWM_BITS-1:0] level1 = '0;
    logic [1:0]          gnt;
    logic                frame_end;
    logic [2:0]          pwm;

    rgb_led_ctrl #(
        .PWM_BITS    (PWM_BITS),
        .STEP_FRAMES (STEP_FRAMES),
        .BREATHE_INC (BREATHE_INC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .color0    (color0),
        .mode0     (mode0),
        .level0    (level0),
        .color1    (color1),
        .mode1     (mode1),
        .level1    (level1),
        .gnt       (gnt),
        .frame_end (frame_end),
        .pwm       (pwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [2:0] color0;
        logic [1:0] mode0;
        logic [7:0] level0;
        logic [2:0] color1;
        logic [1:0] mode1;
        logic [7:0] level1;
        logic [1:0] gnt;
        int         r;
        int         g;
        int         b;
    } vec_t;

    typedef struct {
        logic [1:0] gnt;
        int         r;
        int         g;
        int         b;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[NVEC];
    int   ramps[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [1:0] rq,
                                input logic [2:0] c0, input logic [1:0] m0, input logic [7:0] l0,
                                input logic [2:0] c1, input logic [1:0] m1, input logic [7:0] l1,
                                input logic [1:0] g, input int er, input int eg, input int eb);
        vec_t v;
        v.req = rq; v.color0 = c0; v.mode0 = m0; v.level0 = l0;
        v.color1 = c1; v.mode1 = m1; v.level1 = l1;
        v.gnt = g; v.r = er; v.g = eg; v.b = eb;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        req = v.req;
        color0 = v.color0; mode0 = v.mode0; level0 = v.level0;
        color1 = v.color1; mode1 = v.mode1; level1 = v.level1;
    endtask

    task automatic push_exp(input logic [1:0] g, input int er, input int eg, input int eb);
        exp_t e;
        e.gnt = g; e.r = er; e.g = eg; e.b = eb;
        sb_q.push_back(e);
    endtask

    // Entered at the negedge of a cnt==0 cycle; measures one whole frame and
    // drives the next frame's inputs at cnt==100.
    task automatic run_frame(input string tag, input vec_t v, input bit pulse);
        int         cr, cg, cb, fe_cnt;
        logic [1:0] g0;
        bit         gnt_moved;
        exp_t       e;
        cr = 0; cg = 0; cb = 0; fe_cnt = 0;
        g0 = gnt;
        gnt_moved = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (pulse && k == 30) req = 2'b11;
            if (pulse && k == 60) req = v.req;
            if (k == 100) begin
                apply(v);
                push_exp(v.gnt, v.r, v.g, v.b);
            end
            cr += int'(pwm[0]);
            cg += int'(pwm[1]);
            cb += int'(pwm[2]);
            fe_cnt += int'(frame_end);
            if (k < FRAME && gnt !== g0) gnt_moved = 1'b1;
        end
        check($sformatf("%s frame_end_at_wrap", tag), int'(frame_end), 1);
        check($sformatf("%s frame_end_pulses", tag), fe_cnt, 1);
        check($sformatf("%s gnt_stable", tag), int'(gnt_moved), 0);
        if (sb_q.size() == 0) begin
            check($sformatf("%s scoreboard_empty", tag), 1, 0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("%s gnt", tag), int'(g0), int'(e.gnt));
            check($sformatf("%s pwm_r", tag), cr, e.r);
            check($sformatf("%s pwm_g", tag), cg, e.g);
            check($sformatf("%s pwm_b", tag), cb, e.b);
        end
    endtask

    initial begin
        vec_t       vb, vidle, vsolid;
        int         cnt_on;
        bit         gnt_early;

        vecs[0]  = mk(2'b00, 3'b000, 2'd0, 8'd0,   3'b000, 2'd0, 8'd0,   2'b00, 0,   0,   0);
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = mk(2'b01, 3'b001, 2'd1, 8'd64,  3'b000, 2'd0, 8'd0,   2'b01, 64,  0,   0);
        vecs[4]  = vecs[3];
        vecs[5]  = mk(2'b01, 3'b001, 2'd1, 8'd200, 3'b000, 2'd0, 8'd0,   2'b01, 200, 0,   0);
        vecs[6]  = mk(2'b10, 3'b001, 2'd1, 8'd200, 3'b010, 2'd1, 8'd128, 2'b10, 0,   128, 0);
        vecs[7]  = vecs[6];
        vecs[8]  = mk(2'b11, 3'b001, 2'd1, 8'd200, 3'b010, 2'd1, 8'd128, 2'b01, 200, 0,   0);
        vecs[9]  = vecs[8];
        vecs[10] = vecs[6];
        vecs[11] = mk(2'b00, 3'b001, 2'd1, 8'd200, 3'b010, 2'd1, 8'd128, 2'b00, 0,   0,   0);
        vecs[12] = mk(2'b10, 3'b001, 2'd1, 8'd200, 3'b100, 2'd2, 8'd255, 2'b10, 0,   0,   255);
        vecs[13] = vecs[12];
        vecs[14] = mk(2'b10, 3'b001, 2'd1, 8'd200, 3'b100, 2'd2, 8'd255, 2'b10, 0,   0,   0);
        vecs[15] = vecs[14];
        vecs[16] = vecs[12];
        vecs[17] = vecs[12];
        vecs[18] = vecs[14];

        for (int k = 0; k < 16; k++) ramps.push_back(16 * k);
        ramps.push_back(255);
        for (int k = 1; k < 16; k++) ramps.push_back(255 - 16 * k);
        ramps.push_back(0);
        ramps.push_back(16);
        ramps.push_back(32);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pwm", int'(pwm), 0);
        check("reset gnt", int'(gnt), 0);
        check("reset frame_end", int'(frame_end), 0);
        reset_n = 1'b1;
        push_exp(2'b00, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        for (int t = 0; t < ramps.size(); t++) begin
            for (int h = 0; h < STEP_FRAMES; h++) begin
                vb = mk(2'b01, 3'b001, 2'd3, 8'd255, 3'b100, 2'd2, 8'd255,
                        2'b01, (255 * ramps[t]) >> 8, 0, 0);
                run_frame($sformatf("breathe r%0d.%0d", ramps[t], h), vb, 1'b0);
            end
        end

        vidle  = mk(2'b00, 3'b001, 2'd1, 8'd64, 3'b010, 2'd1, 8'd128, 2'b00, 0, 0, 0);
        vsolid = mk(2'b01, 3'b001, 2'd1, 8'd64, 3'b010, 2'd1, 8'd128, 2'b01, 64, 0, 0);
        run_frame("to_idle", vidle, 1'b0);
        run_frame("pulse", vidle, 1'b1);
        run_frame("after_pulse", vidle, 1'b0);
        run_frame("solid_setup", vsolid, 1'b0);
        run_frame("solid_run", vsolid, 1'b0);

        for (int k = 1; k <= 50; k++) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset pwm", int'(pwm), 0);
        check("midreset gnt", int'(gnt), 0);
        check("midreset frame_end", int'(frame_end), 0);
        reset_n = 1'b1;
        cnt_on = 0;
        gnt_early = 1'b0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            cnt_on += int'(pwm[0]) + int'(pwm[1]) + int'(pwm[2]);
            if (k < FRAME && gnt != 2'b00) gnt_early = 1'b1;
        end
        check("postreset idle_frame_pwm", cnt_on, 0);
        check("postreset gnt_before_wrap", int'(gnt_early), 0);
        check("postreset gnt_at_wrap", int'(gnt), 1);
        check("postreset frame_end", int'(frame_end), 1);
        sb_q.delete();
        push_exp(2'b01, 64, 0, 0);
        run_frame("regrant", vsolid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
